sat_sub3_pipe: RTL and testbench
================================

// Module: sat_sub3_pipe
// PURPOSE
//  Pipelined saturating 3-operand signed subtractor: diff = a - b - c, clamped to W-bit two's complement.
//  Inverse-direction datapath of the RPU 3-input saturating adder; used for residual/error terms in the NE update path.
//  Valid/ready streaming on both sides, 2-stage pipeline.
//  Sticky saturation counter for overflow monitoring.
// PARAMETERS
//  W      6  operand/result width, signed two's complement
//  CNT_W  8  width of saturation event counter
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      reset, synchronous, active-high
//  in_valid   in   1      a/b/c valid
//  in_ready   out  1      block can accept a/b/c this cycle
//  a          in   W      minuend, signed
//  b          in   W      subtrahend 1, signed
//  c          in   W      subtrahend 2, signed
//  out_valid  out  1      diff/flags valid
//  out_ready  in   1      downstream accepts diff this cycle
//  diff       out  W      saturated a-b-c, signed
//  sat_pos    out  1      diff was clamped to +max (2^(W-1)-1)
//  sat_neg    out  1      diff was clamped to -min (-2^(W-1))
//  clr_count  in   1      synchronous clear of sat_count
//  sat_count  out  CNT_W  number of saturated results delivered; sticks at all-ones
// BEHAVIOUR
//  Reset (rst=1 at clk edge): both stage valids=0, out_valid=0, diff=0, sat_pos=0, sat_neg=0, sat_count=0.
//   In-flight data is discarded. in_ready=1 in the first cycle after reset.
//  Stage 1 (S1): on accept (in_valid && in_ready), register
//   r = sext(a) - sext(b) - sext(c), W+2 bits. This width is exact; range -3*2^(W-1)+2 .. 3*2^(W-1)-1.
//  Stage 2 (S2, output regs): clamp r, driven from registers only.
//   r[W+1:W-1] all equal        -> diff=r[W-1:0], flags 0.
//   Not all equal, r[W+1]=0     -> diff={0,1..1}, sat_pos=1.
//   Not all equal, r[W+1]=1     -> diff={1,0..0}, sat_neg=1.
//   sat_pos and sat_neg are never both 1.
//  Handshake:
//   S2 loads from S1 when !out_valid || out_ready.
//   S1 loads when S1 is empty or S1 moves into S2 this cycle.
//   in_ready = !s1_valid || !out_valid || out_ready (combinational, no comb path from in_valid).
//  Latency and throughput:
//   Latency is 2 cycles: accepted at edge N, out_valid at edge N+2 when unstalled.
//   Throughput is 1/cycle with out_ready=1.
//  Stall: while out_valid && !out_ready, diff/sat_pos/sat_neg hold stable.
//   Up to 2 items buffered; after that in_ready=0.
//   Order is preserved; no loss or duplication.
//  Simultaneous accept and deliver when full: allowed, pipeline shifts by one.
//  sat_count:
//   +1 on each output transfer (out_valid && out_ready) with sat_pos|sat_neg.
//   Holds at 2^CNT_W-1 (no wrap).
//   clr_count has priority: clr with a saturating transfer in the same cycle -> 0.
//   Counting is independent of in-flight data; clr does not affect the pipeline.
// TESTING (W=6, CNT_W=8)
//  1 a=10,b=3,c=2, out_ready=1 -> diff=5 two cycles after accept; sat_pos=sat_neg=0; sat_count=0.
//  2 a=31,b=-32,c=-32 (raw 95) -> diff=31, sat_pos=1, sat_count=1.
//    a=-32,b=31,c=31 (raw -94) -> diff=-32, sat_neg=1, sat_count=2.
//  3 Edges: a=-32,b=0,c=0 -> -32, no flag. a=31,b=0,c=0 -> 31, no flag.
//    a=0,b=-32,c=0 (raw 32) -> 31, sat_pos=1. a=-1,b=31,c=0 (raw -32) -> -32, no flag.
//  4 Stream 6 ops, out_ready=0 for 4 cycles mid-stream -> in_ready=0 once 2 items are held;
//    diff stable while stalled; all 6 results in order, none dropped or repeated.
//  5 Drive 260 saturating transfers -> sat_count=255 and holds.
//    clr_count=1 together with a saturating transfer -> sat_count=0 next cycle.
//  6 rst=1 with 2 items in flight -> next cycle out_valid=0, diff=0, flags 0, sat_count=0, in_ready=1;
//    those items are never delivered.

Source files
------------

// File: rtl/sat_sub3_if.sv
// Streaming bus for the 3-operand saturating subtractor: operands in, clamped
// difference and saturation flags out, plus the saturation counter controls.
interface sat_sub3_if #(
    parameter int W     = 6,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [W-1:0]     c;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     diff;
    logic             sat_pos;
    logic             sat_neg;
    logic             clr_count;
    logic [CNT_W-1:0] sat_count;

    modport master (
        output in_valid, a, b, c, out_ready, clr_count,
        input  in_ready, out_valid, diff, sat_pos, sat_neg, sat_count
    );

    modport slave (
        input  in_valid, a, b, c, out_ready, clr_count,
        output in_ready, out_valid, diff, sat_pos, sat_neg, sat_count
    );
endinterface

// File: rtl/sat_sub3_pipe.sv
// Two-stage saturating a-b-c with valid/ready on both sides and a sticky
// count of saturated results handed downstream.
module sat_sub3_pipe #(
    parameter int W     = 6,
    parameter int CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    sat_sub3_if.slave bus
);
    localparam logic [W-1:0]     MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             s1_valid_q, s1_valid_d;
    logic [W+1:0]     s1_r_q, s1_r_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     diff_q, diff_d;
    logic             sat_pos_q, sat_pos_d;
    logic             sat_neg_q, sat_neg_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    logic             s2_load;
    logic             in_ready;
    logic             accept;
    logic             sat_xfer;
    logic [W+1:0]     a_x, b_x, c_x;
    logic [2:0]       top3;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_r_d      = s1_r_q;
        out_valid_d = out_valid_q;
        diff_d      = diff_q;
        sat_pos_d   = sat_pos_q;
        sat_neg_d   = sat_neg_q;
        sat_count_d = sat_count_q;

        s2_load  = !out_valid_q || bus.out_ready;
        in_ready = !s1_valid_q || s2_load;
        accept   = bus.in_valid && in_ready;

        // W+2 bits hold the full range of a-b-c, so no intermediate overflow
        a_x  = {{2{bus.a[W-1]}}, bus.a};
        b_x  = {{2{bus.b[W-1]}}, bus.b};
        c_x  = {{2{bus.c[W-1]}}, bus.c};
        top3 = s1_r_q[W+1:W-1];

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_r_d     = a_x - b_x - c_x;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                if (top3 == 3'b000 || top3 == 3'b111) begin
                    diff_d    = s1_r_q[W-1:0];
                    sat_pos_d = 1'b0;
                    sat_neg_d = 1'b0;
                end else if (!s1_r_q[W+1]) begin
                    diff_d    = MAX_POS;
                    sat_pos_d = 1'b1;
                    sat_neg_d = 1'b0;
                end else begin
                    diff_d    = MIN_NEG;
                    sat_pos_d = 1'b0;
                    sat_neg_d = 1'b1;
                end
            end
        end

        sat_xfer = out_valid_q && bus.out_ready && (sat_pos_q || sat_neg_q);
        if (bus.clr_count) begin
            sat_count_d = '0;
        end else if (sat_xfer && sat_count_q != CNT_MAX) begin
            sat_count_d = sat_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            sat_pos_q   <= 1'b0;
            sat_neg_q   <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            out_valid_q <= out_valid_d;
            diff_q      <= diff_d;
            sat_pos_q   <= sat_pos_d;
            sat_neg_q   <= sat_neg_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.sat_pos   = sat_pos_q;
    assign bus.sat_neg   = sat_neg_q;
    assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_sat_sub3_pipe.sv
// Directed and random stimulus for sat_sub3_pipe, scored against a queue-based
// model of the pipe contents and a clamped integer subtraction.
module tb_sat_sub3_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sat_sub3_if #(.W(6), .CNT_W(8)) bus ();

    sat_sub3_pipe #(.W(6), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int d;
        bit pos;
        bit neg;
        int t;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    model_cnt = 0;
    bit    last_acc;
    bit    last_blocked;
    bit    saw_block;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic item_t ref_op(input logic [5:0] a, input logic [5:0] b,
                                     input logic [5:0] c);
        item_t it;
        int    r;
        r = int'($signed(a)) - int'($signed(b)) - int'($signed(c));
        it.pos = (r > 31);
        it.neg = (r < -32);
        it.d   = it.pos ? 31 : (it.neg ? -32 : r);
        it.t   = 0;
        return it;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, take the edge.
    task automatic step();
        bit    exp_ir;
        bit    exp_ov;
        item_t it;
        @(negedge clk);
        last_acc     = 1'b0;
        last_blocked = 1'b0;
        if (rst) begin
            q.delete();
            model_cnt = 0;
        end else begin
            exp_ir = (q.size() < 2) || bus.out_ready;
            exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
            chk("in_ready", bus.in_ready, exp_ir);
            chk("out_valid", bus.out_valid, exp_ov);
            chk("sat_count", bus.sat_count, model_cnt);
            if (exp_ov) begin
                chk("diff", $signed(bus.diff), q[0].d);
                chk("sat_pos", bus.sat_pos, q[0].pos);
                chk("sat_neg", bus.sat_neg, q[0].neg);
            end
            if (bus.clr_count)
                model_cnt = 0;
            else if (exp_ov && bus.out_ready && (q[0].pos || q[0].neg) && model_cnt < 255)
                model_cnt++;
            if (exp_ov && bus.out_ready)
                void'(q.pop_front());
            if (bus.in_valid && exp_ir) begin
                it   = ref_op(bus.a, bus.b, bus.c);
                it.t = cyc;
                q.push_back(it);
                last_acc = 1'b1;
            end
            if (bus.in_valid && !exp_ir)
                last_blocked = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input int a, input int b, input int c);
        bus.a        = 6'(a);
        bus.b        = 6'(b);
        bus.c        = 6'(c);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (last_acc) break;
        end
        chk("send_accepted", last_acc, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int ops[6][3];
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.c         = '0;
        bus.out_ready = 1'b1;
        bus.clr_count = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_sat_pos", bus.sat_pos, 0);
        chk("rst_sat_neg", bus.sat_neg, 0);
        chk("rst_sat_count", bus.sat_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);

        // basic, saturating and boundary vectors
        send(10, 3, 2);
        drain(3);
        chk("basic_count", bus.sat_count, 0);
        send(31, -32, -32);
        send(-32, 31, 31);
        drain(3);
        chk("sat_pair_count", bus.sat_count, 2);
        send(-32, 0, 0);
        send(31, 0, 0);
        send(0, -32, 0);
        send(-1, 31, 0);
        drain(3);
        chk("edges_count", bus.sat_count, 3);

        // six-op stream with a four-cycle downstream stall
        ops = '{'{1, 2, 3}, '{20, -5, 4}, '{-7, 8, 9}, '{31, -1, 0}, '{-30, 1, 2}, '{5, 5, 5}};
        saw_block = 1'b0;
        begin
            int sent = 0;
            for (int i = 0; i < 40 && sent < 6; i++) begin
                bus.out_ready = !(i >= 2 && i < 6);
                bus.in_valid  = 1'b1;
                bus.a = 6'(ops[sent][0]);
                bus.b = 6'(ops[sent][1]);
                bus.c = 6'(ops[sent][2]);
                step();
                if (last_acc) sent++;
                if (last_blocked) saw_block = 1'b1;
            end
            chk("stream_all_sent", sent, 6);
        end
        chk("stall_blocked_input", saw_block, 1);
        drain(4);
        chk("stream_drained", q.size(), 0);

        // counter saturation at all-ones
        bus.a = 6'(31); bus.b = 6'(-32); bus.c = 6'(-32);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 262; i++) step();
        drain(3);
        chk("count_full", bus.sat_count, 255);
        send(31, -32, -32);
        drain(3);
        chk("count_holds", bus.sat_count, 255);

        // clear coinciding with a saturating transfer
        send(-32, 31, 31);
        step();
        bus.clr_count = 1'b1;
        step();
        bus.clr_count = 1'b0;
        chk("clr_priority", bus.sat_count, 0);
        drain(2);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.clr_count = ($urandom_range(0, 31) == 0);
            bus.a = 6'($urandom_range(0, 63));
            bus.b = 6'($urandom_range(0, 63));
            bus.c = 6'($urandom_range(0, 63));
            step();
        end
        bus.clr_count = 1'b0;
        drain(4);
        chk("random_drained", q.size(), 0);

        // reset with two items in flight
        send(0, -32, 0);
        drain(3);
        bus.out_ready = 1'b0;
        send(1, 1, 1);
        send(2, 2, 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_out_valid", bus.out_valid, 0);
        chk("rst2_diff", bus.diff, 0);
        chk("rst2_sat_pos", bus.sat_pos, 0);
        chk("rst2_sat_neg", bus.sat_neg, 0);
        chk("rst2_sat_count", bus.sat_count, 0);
        chk("rst2_in_ready", bus.in_ready, 1);
        drain(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
